// File: rtl/f_norm_pkg.sv
// Shared rounding-mode encoding and floating-point constants for f_norm_rnd.
package f_norm_pkg;
    typedef enum logic [1:0] {
        RND_RNE = 2'b00,
        RND_RTZ = 2'b01,
        RND_RUP = 2'b10,
        RND_RDN = 2'b11
    } rnd_mode_t;

    localparam int EXP_BIAS = 1023;
    localparam int EMAX     = 2047;
    localparam int N_STAGES = 4;
endpackage

// File: rtl/f_norm_clz_seg.sv
// Leading-zero counter for one SEG_W-bit segment; an all-zero segment reports 0
// because the caller already knows it is empty from its segment-zero flag.
module clz_seg
    import f_norm_pkg::*;
#(
    parameter int SEG_W = 16
) (
    input  logic [SEG_W-1:0]         seg,
    output logic [$clog2(SEG_W)-1:0] cnt
);
    localparam int CNT_W = $clog2(SEG_W);

    always_comb begin
        cnt = '0;
        for (int i = 0; i < SEG_W; i++) begin
            if (seg[i]) cnt = CNT_W'(SEG_W - 1 - i);
        end
    end
endmodule

// File: rtl/f_norm_rnd.sv
// Four-stage normalise-and-round pipeline: abs value, leading-zero count, shift, round.
// Define F_NORM_EXC_EN to enable overflow saturation and underflow flush-to-zero.
module f_norm_rnd
    import f_norm_pkg::*;
#(
    parameter int FRAC_W = 108,
    parameter int EXP_W  = 13,
    parameter int MAN_W  = 52,
    parameter int INFO_W = 1,
    parameter int SEG_W  = 16
) (
    input  logic              clk,
    input  logic              resetn,
    input  logic              a_wait,
    input  logic              flush,
    input  logic [EXP_W-1:0]  exp,
    input  logic [FRAC_W-1:0] frac,
    input  logic              frac_signed,
    input  logic              frac_sign,
    input  logic [1:0]        rnd_mode,
    input  logic              op_invalid,
    input  logic [INFO_W-1:0] info_in,
    output logic [INFO_W-1:0] info_out,
    output logic [MAN_W-1:0]  result_frac,
    output logic [EXP_W-1:0]  result_exp,
    output logic              result_sign,
    output logic              invalid,
    output logic              overflow,
    output logic              underflow,
    output logic              inexact,
    output logic              zero,
    output logic              busy
);
    localparam int SIG_W  = FRAC_W - 2;
    localparam int NSEG   = (SIG_W + SEG_W - 1) / SEG_W;
    localparam int PAD_W  = NSEG * SEG_W;
    localparam int SEGC_W = $clog2(SEG_W);
    localparam int CNT_W  = $clog2(PAD_W);
    localparam int LO_W   = SIG_W - 2 - MAN_W;
    // Sideband word carried alongside the data: {invalid, sign, rnd_mode, info}
    localparam int SIDE_W = INFO_W + 4;
    localparam int RND_LO = INFO_W;
    localparam int SIGN_B = INFO_W + 2;
    localparam int INV_B  = INFO_W + 3;
`ifdef F_NORM_EXC_EN
    localparam logic signed [EXP_W-1:0] EXP_TOP = EXP_W'((1 << (EXP_W - 2)) - 1);
    localparam logic signed [EXP_W-1:0] EXP_SAT = EXP_W'((1 << (EXP_W - 2)) - 2);
`endif

    logic [SIG_W:0]            mag_c, mag_s1;
    logic [PAD_W-1:0]          pad_c, pad_s1;
    logic [NSEG-1:0]           segz_c, segz_s1;
    logic [SIDE_W-1:0]         side_c, side_s1, side_s2, side_s3;
    logic signed [EXP_W-1:0]   exp_s1, exp_s2, exp_s3, exp_c;
    logic [SEGC_W-1:0]         segcnt [NSEG];
    logic [CNT_W-1:0]          cnt_c, cnt_s2;
    logic                      allz_c, ovf_bit_c, zero_s2, zero_s3;
    logic [SIG_W-1:0]          mag_s2;
    logic [SIG_W-2:0]          norm_s3;
    logic [MAN_W-1:0]          mant_c, frac_c;
    logic                      guard_c, sticky_c, inexact_c, inc_c, carry_c, ovf_c, unf_c;
    rnd_mode_t                 rm;

    logic [INFO_W-1:0]         info_out_reg;
    logic [MAN_W-1:0]          frac_reg;
    logic [EXP_W-1:0]          exp_reg;
    logic                      sign_reg, invalid_reg, overflow_reg, underflow_reg;
    logic                      inexact_reg, zero_reg;

    // S1: magnitude, with the leading-one window left-aligned into whole segments
    always_comb begin
        mag_c = frac[FRAC_W-2:0];
        if (frac_signed && frac[FRAC_W-1]) mag_c = (FRAC_W-1)'(-frac);
        pad_c  = PAD_W'(mag_c[SIG_W-1:0]) << (PAD_W - SIG_W);
        side_c = {op_invalid, (frac_signed ? frac[FRAC_W-1] : frac_sign), rnd_mode, info_in};
    end

    for (genvar gi = 0; gi < NSEG; gi++) begin : g_segz
        assign segz_c[gi] = ~|pad_c[PAD_W-1-gi*SEG_W -: SEG_W];
    end

    // S2: per-segment counts, first non-empty segment wins
    assign pad_s1    = PAD_W'(mag_s1[SIG_W-1:0]) << (PAD_W - SIG_W);
    assign ovf_bit_c = mag_s1[SIG_W];

    for (genvar gi = 0; gi < NSEG; gi++) begin : g_clz
        clz_seg #(.SEG_W(SEG_W)) u_clz_seg (
            .seg (pad_s1[PAD_W-1-gi*SEG_W -: SEG_W]),
            .cnt (segcnt[gi])
        );
    end

    always_comb begin
        cnt_c  = '0;
        allz_c = 1'b1;
        for (int i = NSEG - 1; i >= 0; i--) begin
            if (!segz_s1[i]) begin
                cnt_c  = CNT_W'(i * SEG_W) + CNT_W'(segcnt[i]);
                allz_c = 1'b0;
            end
        end
    end

    // S4: round, then apply exception overrides
    always_comb begin
        rm        = rnd_mode_t'(side_s3[RND_LO +: 2]);
        mant_c    = norm_s3[SIG_W-2 -: MAN_W];
        guard_c   = norm_s3[LO_W];
        sticky_c  = |norm_s3[LO_W-1:0];
        inexact_c = guard_c | sticky_c;
        inc_c     = 1'b0;
        case (rm)
            RND_RNE: inc_c = guard_c & (sticky_c | mant_c[0]);
            RND_RTZ: inc_c = 1'b0;
            RND_RUP: inc_c = inexact_c & ~side_s3[SIGN_B];
            RND_RDN: inc_c = inexact_c & side_s3[SIGN_B];
            default: inc_c = 1'b0;
        endcase
        {carry_c, frac_c} = {1'b0, mant_c} + (MAN_W + 1)'(inc_c);
        exp_c = exp_s3 + EXP_W'(carry_c);
        ovf_c = 1'b0;
        unf_c = 1'b0;
`ifdef F_NORM_EXC_EN
        if (exp_c >= EXP_TOP) begin
            ovf_c = 1'b1;
            if ((rm == RND_RNE) || (rm == RND_RUP && !side_s3[SIGN_B]) ||
                (rm == RND_RDN && side_s3[SIGN_B])) begin
                exp_c  = EXP_TOP;
                frac_c = '0;
            end else begin
                exp_c  = EXP_SAT;
                frac_c = '1;
            end
        end else if (exp_c[EXP_W-1] || exp_c == '0) begin
            unf_c     = 1'b1;
            inexact_c = 1'b1;
            exp_c     = '0;
            frac_c    = '0;
        end
`endif
        if (zero_s3) begin
            exp_c     = '0;
            frac_c    = '0;
            inexact_c = 1'b0;
            ovf_c     = 1'b0;
            unf_c     = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            mag_s1 <= '0; segz_s1 <= '0; exp_s1 <= '0; side_s1 <= '0;
            mag_s2 <= '0; cnt_s2 <= '0; exp_s2 <= '0; zero_s2 <= 1'b0; side_s2 <= '0;
            norm_s3 <= '0; exp_s3 <= '0; zero_s3 <= 1'b0; side_s3 <= '0;
            info_out_reg <= '0; frac_reg <= '0; exp_reg <= '0; sign_reg <= 1'b0;
            invalid_reg <= 1'b0; overflow_reg <= 1'b0; underflow_reg <= 1'b0;
            inexact_reg <= 1'b0; zero_reg <= 1'b0;
        end else begin
            if (!a_wait) begin
                mag_s1  <= mag_c;
                segz_s1 <= segz_c;
                exp_s1  <= exp;
                side_s1 <= side_c;

                mag_s2  <= ovf_bit_c ? mag_s1[SIG_W:1] : mag_s1[SIG_W-1:0];
                cnt_s2  <= ovf_bit_c ? '0 : cnt_c;
                exp_s2  <= ovf_bit_c ? exp_s1 + EXP_W'(1) : exp_s1;
                zero_s2 <= allz_c & ~ovf_bit_c;
                side_s2 <= side_s1;

                norm_s3 <= (SIG_W - 1)'(mag_s2 << cnt_s2);
                exp_s3  <= exp_s2 - EXP_W'(cnt_s2);
                zero_s3 <= zero_s2;
                side_s3 <= side_s2;

                info_out_reg  <= side_s3[INFO_W-1:0];
                invalid_reg   <= side_s3[INV_B];
                sign_reg      <= side_s3[SIGN_B];
                frac_reg      <= frac_c;
                exp_reg       <= exp_c;
                overflow_reg  <= ovf_c;
                underflow_reg <= unf_c;
                inexact_reg   <= inexact_c;
                zero_reg      <= zero_s3;
            end
            // Flush kills the valid bit everywhere, even while stalled
            if (flush) begin
                side_s1[0]      <= 1'b0;
                side_s2[0]      <= 1'b0;
                side_s3[0]      <= 1'b0;
                info_out_reg[0] <= 1'b0;
            end
        end
    end

    assign info_out    = info_out_reg;
    assign result_frac = frac_reg;
    assign result_exp  = exp_reg;
    assign result_sign = sign_reg;
    assign invalid     = invalid_reg;
    assign overflow    = overflow_reg;
    assign underflow   = underflow_reg;
    assign inexact     = inexact_reg;
    assign zero        = zero_reg;
    assign busy        = a_wait;
endmodule

// File: tb/tb_f_norm_rnd.sv
// Self-checking bench for f_norm_rnd: directed corner vectors, stall/flush, mid-run
// reset and a randomized stream compared against a bit-position reference model.
module tb_f_norm_rnd;
    localparam int FRAC_W = 108;
    localparam int EXP_W  = 13;
    localparam int MAN_W  = 52;
    localparam int INFO_W = 1;
`ifdef F_NORM_EXC_EN
    localparam bit EXC = 1'b1;
`else
    localparam bit EXC = 1'b0;
`endif

    typedef struct packed {
        logic             info;
        logic             inv;
        logic             zr;
        logic             inx;
        logic             unf;
        logic             ovf;
        logic             sgn;
        logic [EXP_W-1:0] e;
        logic [MAN_W-1:0] f;
    } res_t;

    logic              clk = 1'b0;
    logic              resetn = 1'b0;
    logic              a_wait = 1'b0;
    logic              flush = 1'b0;
    logic [EXP_W-1:0]  exp_in = '0;
    logic [FRAC_W-1:0] frac_in = '0;
    logic              frac_signed = 1'b0;
    logic              frac_sign = 1'b0;
    logic [1:0]        rnd_mode = 2'b00;
    logic              op_invalid = 1'b0;
    logic [INFO_W-1:0] info_in = '0;
    logic [INFO_W-1:0] info_out;
    logic [MAN_W-1:0]  result_frac;
    logic [EXP_W-1:0]  result_exp;
    logic              result_sign, invalid, overflow, underflow, inexact, zero, busy;

    f_norm_rnd #(.FRAC_W(FRAC_W), .EXP_W(EXP_W), .MAN_W(MAN_W), .INFO_W(INFO_W), .SEG_W(16)) dut (
        .clk(clk), .resetn(resetn), .a_wait(a_wait), .flush(flush), .exp(exp_in),
        .frac(frac_in), .frac_signed(frac_signed), .frac_sign(frac_sign),
        .rnd_mode(rnd_mode), .op_invalid(op_invalid), .info_in(info_in),
        .info_out(info_out), .result_frac(result_frac), .result_exp(result_exp),
        .result_sign(result_sign), .invalid(invalid), .overflow(overflow),
        .underflow(underflow), .inexact(inexact), .zero(zero), .busy(busy)
    );

    always #5 clk = ~clk;

    int   n_vec = 0;
    int   n_bad = 0;
    res_t exp_q[$];
    string tag_q[$];

    task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] want);
        n_vec++;
        if (got !== want) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", tag, got, want);
        end
    endtask

    function automatic res_t got_out();
        return {info_out[0], invalid, zero, inexact, underflow, overflow, result_sign,
                result_exp, result_frac};
    endfunction

    function automatic res_t mk(input logic info, input logic inv, input logic zr,
                                input logic inx, input logic unf, input logic ovf,
                                input logic sgn, input int e, input logic [MAN_W-1:0] f);
        res_t r;
        r.info = info; r.inv = inv; r.zr = zr; r.inx = inx;
        r.unf = unf; r.ovf = ovf; r.sgn = sgn; r.e = e[EXP_W-1:0]; r.f = f;
        return r;
    endfunction

    // Reference: locate the leading one, read mantissa/guard/sticky by bit position.
    function automatic res_t model(input int e_in, input logic [FRAC_W-1:0] fr,
                                   input logic sgd, input logic sgn_in, input logic [1:0] rm,
                                   input logic inv, input logic info);
        res_t r;
        logic [FRAC_W-1:0] m;
        logic [63:0] mant;
        logic g, st, inc;
        int p, e;
        r = '0;
        r.info = info;
        r.inv  = inv;
        r.sgn  = sgd ? fr[FRAC_W-1] : sgn_in;
        m = (sgd && fr[FRAC_W-1]) ? -fr : fr;
        m[FRAC_W-1] = 1'b0;
        p = -1;
        for (int i = 0; i <= FRAC_W - 2; i++) if (m[i]) p = i;
        if (p < 0) begin
            r.zr = 1'b1;
            return r;
        end
        e = e_in;
        if (p == FRAC_W - 2) begin
            m = m >> 1;
            p = FRAC_W - 3;
            e = e + 1;
        end
        e = e - (FRAC_W - 3 - p);
        mant = '0;
        g = 1'b0;
        st = 1'b0;
        for (int i = 0; i < MAN_W; i++) if (p - 1 - i >= 0) mant[MAN_W-1-i] = m[p-1-i];
        if (p - MAN_W - 1 >= 0) g = m[p-MAN_W-1];
        for (int j = 0; j < p - MAN_W - 1; j++) st = st | m[j];
        r.inx = g | st;
        case (rm)
            2'd0:    inc = g & (st | mant[0]);
            2'd1:    inc = 1'b0;
            2'd2:    inc = r.inx & ~r.sgn;
            default: inc = r.inx & r.sgn;
        endcase
        mant = mant + 64'(inc);
        if (mant[MAN_W]) begin
            mant = '0;
            e = e + 1;
        end
        if (EXC) begin
            if (e >= 2047) begin
                r.ovf = 1'b1;
                if (rm == 2'd0 || (rm == 2'd2 && !r.sgn) || (rm == 2'd3 && r.sgn)) begin
                    e = 2047;
                    mant = '0;
                end else begin
                    e = 2046;
                    mant = 64'({MAN_W{1'b1}});
                end
            end else if (e <= 0) begin
                r.unf = 1'b1;
                r.inx = 1'b1;
                e = 0;
                mant = '0;
            end
        end
        r.e = e[EXP_W-1:0];
        r.f = mant[MAN_W-1:0];
        return r;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input int e, input logic [FRAC_W-1:0] fr, input logic sgd,
                         input logic sgn, input logic [1:0] rm, input logic inv, input logic info);
        exp_in = EXP_W'(e); frac_in = fr; frac_signed = sgd; frac_sign = sgn;
        rnd_mode = rm; op_invalid = inv; info_in = INFO_W'(info);
    endtask

    task automatic pop_check();
        res_t w;
        string t;
        w = exp_q.pop_front();
        t = tag_q.pop_front();
        chk(t, 128'(got_out()), 128'(w));
    endtask

    // Issue one vector per cycle; the result for a vector emerges 4 edges later.
    task automatic apply(input string tag, input int e, input logic [FRAC_W-1:0] fr,
                         input logic sgd, input logic sgn, input logic [1:0] rm,
                         input logic inv, input logic info, input res_t want);
        if (exp_q.size() == 4) pop_check();
        drive(e, fr, sgd, sgn, rm, inv, info);
        exp_q.push_back(want);
        tag_q.push_back(tag);
        tick();
    endtask

    task automatic apply_m(input string tag, input int e, input logic [FRAC_W-1:0] fr,
                           input logic sgd, input logic sgn, input logic [1:0] rm,
                           input logic inv, input logic info);
        apply(tag, e, fr, sgd, sgn, rm, inv, info, model(e, fr, sgd, sgn, rm, inv, info));
    endtask

    task automatic drain();
        while (exp_q.size() > 0) begin
            pop_check();
            drive(0, '0, 1'b0, 1'b0, 2'd0, 1'b0, 1'b0);
            tick();
        end
    endtask

    logic [FRAC_W-1:0] one, fr, cfr;
    logic [MAN_W-1:0]  ones;
    res_t              v, y;
    logic              sgd;
    int                e;

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        one  = FRAC_W'(1);
        ones = '1;
        tick();
        drive(1500, one << 100, 1'b0, 1'b1, 2'd2, 1'b1, 1'b1);
        repeat (3) tick();
        chk("reset_state", 128'(got_out()), 128'(0));
        resetn = 1'b1;

        cfr = ((one << 54) - one) << 52;
        apply("d_unity_rne", 1023, one << 105, 0, 0, 2'd0, 0, 1, mk(1, 0, 0, 0, 0, 0, 0, 1023, '0));
        apply("d_neg_ovfbit", 1000, -(one << 106), 1, 0, 2'd0, 0, 1, mk(1, 0, 0, 0, 0, 0, 1, 1001, '0));
        apply("d_tie_rne", 1023, (one << 105) | (one << 52), 0, 0, 2'd0, 0, 1,
              mk(1, 0, 0, 1, 0, 0, 0, 1023, '0));
        apply("d_tie_rup", 1023, (one << 105) | (one << 52), 0, 0, 2'd2, 0, 1,
              mk(1, 0, 0, 1, 0, 0, 0, 1023, 52'd1));
        apply("d_carry_rne", 2046, cfr, 0, 0, 2'd0, 0, 1, mk(1, 0, 0, 1, 0, EXC, 0, 2047, '0));
        apply("d_carry_rtz", 2046, cfr, 0, 0, 2'd1, 0, 1, mk(1, 0, 0, 1, 0, 0, 0, 2046, ones));
        apply("d_underflow", 40, one << 60, 0, 0, 2'd0, 0, 1,
              EXC ? mk(1, 0, 0, 1, 1, 0, 0, 0, '0) : mk(1, 0, 0, 0, 0, 0, 0, -5, '0));
        apply("d_zero", 500, '0, 0, 1, 2'd0, 0, 1, mk(1, 0, 1, 0, 0, 0, 1, 0, '0));
        apply("d_sat_rtz", 3000, one << 105, 0, 0, 2'd1, 0, 1,
              EXC ? mk(1, 0, 0, 0, 0, 1, 0, 2046, ones) : mk(1, 0, 0, 0, 0, 0, 0, 3000, '0));
        apply("d_sat_rdn_neg", 3000, one << 105, 0, 1, 2'd3, 1, 1,
              EXC ? mk(1, 1, 0, 0, 0, 1, 1, 2047, '0) : mk(1, 1, 0, 0, 0, 0, 1, 3000, '0));
        drain();

        for (int n = 0; n < 400; n++) begin
            fr = FRAC_W'({$urandom, $urandom, $urandom, $urandom});
            fr = fr >> $urandom_range(0, FRAC_W - 1);
            if ($urandom_range(0, 3) == 0) fr = fr & ~((one << $urandom_range(0, 60)) - one);
            if ($urandom_range(0, 20) == 0) fr = '0;
            sgd = 1'($urandom_range(0, 1));
            if (!sgd) fr[FRAC_W-1] = 1'b0;
            else if ($urandom_range(0, 1) == 1) fr = -fr;
            e = int'($urandom_range(0, 2400)) - 200;
            apply_m("rand", e, fr, sgd, 1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)),
                    1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
        end
        drain();

        // Stall holds the output steady; flush (even while stalled) kills in-flight valids
        v = model(1100, (one << 100) | FRAC_W'(12345), 0, 0, 2'd0, 0, 1);
        drive(1100, (one << 100) | FRAC_W'(12345), 0, 0, 2'd0, 0, 1);
        tick();
        for (int k = 0; k < 3; k++) begin
            drive(900 + k, one << (90 - k), 0, 0, 2'd0, 0, 1);
            tick();
        end
        chk("stall_first", 128'(got_out()), 128'(v));
        a_wait = 1'b1;
        drive(700, one << 80, 0, 0, 2'd0, 0, 1);
        for (int k = 0; k < 3; k++) begin
            tick();
            chk("stall_hold", 128'(got_out()), 128'(v));
            chk("stall_busy", 128'(busy), 128'(1));
        end
        flush = 1'b1;
        tick();
        v.info = 1'b0;
        chk("flush_held", 128'(got_out()), 128'(v));
        a_wait = 1'b0;
        flush  = 1'b0;
        drive(0, '0, 0, 0, 2'd0, 0, 0);
        for (int k = 0; k < 4; k++) begin
            tick();
            chk("flush_info", 128'(info_out), 128'(0));
        end
        chk("busy_idle", 128'(busy), 128'(0));

        // Reset mid-flight discards everything; a new vector needs the full 4 cycles
        for (int k = 0; k < 3; k++) begin
            drive(1200, one << (100 - k), 0, 0, 2'd0, 0, 1);
            tick();
        end
        resetn = 1'b0;
        tick();
        chk("reset_mid", 128'(got_out()), 128'(0));
        resetn = 1'b1;
        y = model(1300, (one << 99) | FRAC_W'(777), 0, 1, 2'd3, 0, 1);
        drive(1300, (one << 99) | FRAC_W'(777), 0, 1, 2'd3, 0, 1);
        tick();
        drive(0, '0, 0, 0, 2'd0, 0, 0);
        for (int k = 0; k < 2; k++) begin
            tick();
            chk("reset_gap", 128'(info_out), 128'(0));
        end
        tick();
        chk("reset_first", 128'(got_out()), 128'(y));

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule
